aurora_rx_lane: RTL

- Receive-side counterpart of the single-lane simplex TX path.
- Consumes one 66-bit 64B/66B block per valid cycle and hunts for sync-header block lock, driving a slip request to the gearbox while hunting.
- Once locked, verifies the link using idle blocks and deframes data/separator blocks into a push-only AXI-stream (no backpressure, matching the TX side).
- Sits per lane between the gearbox/deserializer and user logic. Its status outputs supply the partner's simplex_aligned / simplex_verified sideband.

---
 rtl/aurora_pkg.sv | 36 +++
 rtl/aurora_rx_lane_if.sv | 17 +
 rtl/aurora_rx_block_lock.sv | 113 +++++++++++
 rtl/aurora_rx_lane.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared types, constants and helpers for the Aurora 64B/66B receive lane.
package aurora_pkg;

  localparam int unsigned ENCODED_DATA_SIZE = 66;
  localparam int unsigned AXI_DATA_SIZE     = 64;
  localparam int unsigned AXI_KEEP_SIZE     = AXI_DATA_SIZE / 8;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BTF_IDLE = 8'h78;
  localparam logic [7:0] BTF_SEP  = 8'h1E;
  localparam logic [7:0] BTF_SEP7 = 8'hE1;

  typedef enum logic [1:0] {HUNT, SLIP_WAIT, LOCKED} rx_lock_state_t;

  typedef struct packed {
    logic [AXI_DATA_SIZE-1:0] data;
    logic [AXI_KEEP_SIZE-1:0] keep;
    logic                     last;
  } axi_beat_t;

  // Expand byte enables into a bit mask over the data word.
  function automatic logic [AXI_DATA_SIZE-1:0] keep_mask(input logic [AXI_KEEP_SIZE-1:0] keep);
    logic [AXI_DATA_SIZE-1:0] m;
    m = '0;
    for (int i = 0; i < int'(AXI_KEEP_SIZE); i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

  // N most-significant keep bits set, N in 1..6.
  function automatic logic [AXI_KEEP_SIZE-1:0] sep_keep(input logic [2:0] n);
    return AXI_KEEP_SIZE'(8'hFF << (4'd8 - 4'(n)));
  endfunction

endpackage

// File: rtl/aurora_rx_lane_if.sv
// Block input and push-only AXI-stream output of one receive lane.
interface aurora_rx_lane_if;
  import aurora_pkg::*;

  logic                         enc_valid;
  logic [ENCODED_DATA_SIZE-1:0] encoded_data;
  logic                         axi_valid;
  logic                         axi_last;
  logic [AXI_KEEP_SIZE-1:0]     axi_keep;
  logic [AXI_DATA_SIZE-1:0]     axi_data;

  // master: block source / stream sink; slave: the receive lane itself
  modport master (output enc_valid, encoded_data,
                  input  axi_valid, axi_last, axi_keep, axi_data);
  modport slave  (input  enc_valid, encoded_data,
                  output axi_valid, axi_last, axi_keep, axi_data);
endinterface

// File: rtl/aurora_rx_block_lock.sv
// Sync-header block lock: hunt with gearbox slip, then windowed bad-header monitor.
module aurora_rx_block_lock
  import aurora_pkg::*;
#(
  parameter int unsigned LOCK_GOOD_CNT = 64,
  parameter int unsigned SLIP_WAIT     = 32,
  parameter int unsigned BAD_WIN       = 64,
  parameter int unsigned BAD_MAX       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_valid,
  input  logic [1:0] sync_hdr,
  output logic       rx_slip,
  output logic       simplex_aligned,
  output logic       lock_drop_c
);

  localparam int unsigned GW = $clog2(LOCK_GOOD_CNT + 1);
  localparam int unsigned WW = $clog2(SLIP_WAIT + 1);
  localparam int unsigned BW = $clog2(BAD_WIN + 1);
  localparam int unsigned MW = $clog2(BAD_MAX + 1);

  rx_lock_state_t state_q, state_d;
  logic [GW-1:0]  good_cnt_q, good_cnt_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BW-1:0]  blk_cnt_q, blk_cnt_d;
  logic [MW-1:0]  bad_cnt_q, bad_cnt_d;
  logic           slip_q, slip_d;
  logic           aligned_q, aligned_d;
  logic           hdr_ok;

  assign hdr_ok = (sync_hdr == SYNC_DATA) || (sync_hdr == SYNC_CTRL);

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    slip_d      = 1'b0;
    aligned_d   = aligned_q;
    lock_drop_c = 1'b0;
    unique case (state_q)
      HUNT: if (enc_valid) begin
        if (!hdr_ok) begin
          slip_d     = 1'b1;
          good_cnt_d = '0;
          wait_cnt_d = '0;
          state_d    = aurora_pkg::SLIP_WAIT;
        end else if (good_cnt_q == GW'(LOCK_GOOD_CNT - 1)) begin
          good_cnt_d = '0;
          blk_cnt_d  = '0;
          bad_cnt_d  = '0;
          aligned_d  = 1'b1;
          state_d    = LOCKED;
        end else begin
          good_cnt_d = good_cnt_q + GW'(1);
        end
      end
      // Gearbox settling time counts raw clocks, not blocks.
      aurora_pkg::SLIP_WAIT: begin
        if (wait_cnt_q == WW'(SLIP_WAIT - 1)) begin
          wait_cnt_d = '0;
          state_d    = HUNT;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      LOCKED: if (enc_valid) begin
        if (!hdr_ok && (bad_cnt_q == MW'(BAD_MAX - 1))) begin
          lock_drop_c = 1'b1;
          aligned_d   = 1'b0;
          good_cnt_d  = '0;
          blk_cnt_d   = '0;
          bad_cnt_d   = '0;
          state_d     = HUNT;
        end else if (blk_cnt_q == BW'(BAD_WIN - 1)) begin
          blk_cnt_d = '0;
          bad_cnt_d = '0;
        end else begin
          blk_cnt_d = blk_cnt_q + BW'(1);
          if (!hdr_ok) bad_cnt_d = bad_cnt_q + MW'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      good_cnt_q <= '0;
      wait_cnt_q <= '0;
      blk_cnt_q  <= '0;
      bad_cnt_q  <= '0;
      slip_q     <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      slip_q     <= slip_d;
      aligned_q  <= aligned_d;
    end
  end

  assign rx_slip         = slip_q;
  assign simplex_aligned = aligned_q;

endmodule

// File: rtl/aurora_rx_lane.sv
// Aurora simplex RX lane: block lock, idle-based verification and deframing to AXI-stream.
module aurora_rx_lane
  import aurora_pkg::*;
#(
  parameter int unsigned LOCK_GOOD_CNT = 64,
  parameter int unsigned SLIP_WAIT     = 32,
  parameter int unsigned BAD_WIN       = 64,
  parameter int unsigned BAD_MAX       = 16,
  parameter int unsigned VERIFY_IDLES  = 64
) (
  input  logic             clk,
  input  logic             rst,
  aurora_rx_lane_if.slave  lane,
  output logic             rx_slip,
  output logic             simplex_aligned,
  output logic             simplex_verified,
  output logic             rx_frame_err
);

  localparam int unsigned VW = $clog2(VERIFY_IDLES + 1);

  logic [1:0]               sync_hdr;
  logic [7:0]               btype;
  logic [7:0]               byte1;
  logic                     lock_drop_c;
  logic                     idle_ready;

  logic [VW-1:0]            idle_cnt_q, idle_cnt_d;
  logic                     verified_q, verified_d;
  logic                     hold_vld_q, hold_vld_d;
  logic [AXI_DATA_SIZE-1:0] hold_data_q, hold_data_d;
  logic                     skid_vld_q, skid_vld_d;
  axi_beat_t                skid_q, skid_d;
  logic                     out_vld_q, out_vld_d;
  axi_beat_t                out_q, out_d;
  logic                     frame_err_q, frame_err_d;

  logic                     emit_held, held_last, sep_vld;
  axi_beat_t                held_beat, sep_beat, first_beat;

  assign sync_hdr   = lane.encoded_data[65:64];
  assign btype      = lane.encoded_data[63:56];
  assign byte1      = lane.encoded_data[55:48];
  assign idle_ready = (sync_hdr == SYNC_CTRL) && (btype == BTF_IDLE) && !byte1[7];

  aurora_rx_block_lock #(
    .LOCK_GOOD_CNT (LOCK_GOOD_CNT),
    .SLIP_WAIT     (SLIP_WAIT),
    .BAD_WIN       (BAD_WIN),
    .BAD_MAX       (BAD_MAX)
  ) u_block_lock (
    .clk             (clk),
    .rst             (rst),
    .enc_valid       (lane.enc_valid),
    .sync_hdr        (sync_hdr),
    .rx_slip         (rx_slip),
    .simplex_aligned (simplex_aligned),
    .lock_drop_c     (lock_drop_c)
  );

  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    verified_d  = verified_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    skid_vld_d  = 1'b0;
    skid_d      = skid_q;
    out_vld_d   = 1'b0;
    out_d       = '0;
    frame_err_d = 1'b0;
    emit_held   = 1'b0;
    held_last   = 1'b0;
    sep_vld     = 1'b0;
    sep_beat    = '0;
    held_beat   = '0;
    first_beat  = '0;

    if (lane.enc_valid) begin
      // Verification: count back-to-back ready idles; sticky until lock loss.
      if (lock_drop_c) begin
        idle_cnt_d = '0;
        verified_d = 1'b0;
      end else if (simplex_aligned && !verified_q) begin
        if (idle_ready) begin
          idle_cnt_d = idle_cnt_q + VW'(1);
          if (idle_cnt_q == VW'(VERIFY_IDLES - 1)) verified_d = 1'b1;
        end else begin
          idle_cnt_d = '0;
        end
      end

      if (verified_q) begin
        if (sync_hdr == SYNC_DATA) begin
          emit_held   = hold_vld_q;
          hold_vld_d  = 1'b1;
          hold_data_d = lane.encoded_data[63:0];
        end else if (sync_hdr == SYNC_CTRL) begin
          case (btype)
            BTF_IDLE: hold_vld_d = hold_vld_q;
            BTF_SEP: begin
              hold_vld_d = 1'b0;
              if (byte1 == 8'd0) begin
                emit_held = hold_vld_q;
                held_last = 1'b1;
              end else if (byte1 <= 8'd6) begin
                emit_held     = hold_vld_q;
                sep_vld       = 1'b1;
                sep_beat.keep = sep_keep(byte1[2:0]);
                sep_beat.data = {lane.encoded_data[47:0], 16'h0000} & keep_mask(sep_keep(byte1[2:0]));
                sep_beat.last = 1'b1;
              end else begin
                frame_err_d = 1'b1;
              end
            end
            BTF_SEP7: begin
              hold_vld_d    = 1'b0;
              emit_held     = hold_vld_q;
              sep_vld       = 1'b1;
              sep_beat.keep = 8'hFE;
              sep_beat.data = {lane.encoded_data[55:0], 8'h00};
              sep_beat.last = 1'b1;
            end
            default: begin
              hold_vld_d  = 1'b0;
              frame_err_d = 1'b1;
            end
          endcase
        end else begin
          // Corrupt header (including the one that drops lock) kills an open frame.
          hold_vld_d  = 1'b0;
          frame_err_d = hold_vld_q;
        end
      end
    end

    held_beat.data = hold_data_q;
    held_beat.keep = 8'hFF;
    held_beat.last = held_last;
    first_beat     = emit_held ? held_beat : sep_beat;

    // At most two beats per block; a pending skid beat always goes out first.
    if (skid_vld_q) begin
      out_vld_d  = 1'b1;
      out_d      = skid_q;
      skid_vld_d = emit_held | sep_vld;
      skid_d     = first_beat;
    end else begin
      out_vld_d  = emit_held | sep_vld;
      out_d      = first_beat;
      skid_vld_d = emit_held & sep_vld;
      skid_d     = sep_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q  <= '0;
      verified_q  <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_q      <= '0;
      out_vld_q   <= 1'b0;
      out_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      verified_q  <= verified_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_q      <= skid_d;
      out_vld_q   <= out_vld_d;
      out_q       <= out_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign lane.axi_valid   = out_vld_q;
  assign lane.axi_last    = out_q.last;
  assign lane.axi_keep    = out_q.keep;
  assign lane.axi_data    = out_q.data;
  assign simplex_verified = verified_q;
  assign rx_frame_err     = frame_err_q;

endmodule
